// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions for the ID/EX load-use hazard detection unit.
package hazard_detect_unit_pkg;

    // Default register address width of the 5-stage RISC-V pipeline.
    localparam int unsigned REG_AW_DEF = 5;

    // Default performance counter width.
    localparam int unsigned CNT_W_DEF = 16;

    // Width of the bubble sequencing counter; bounds LOAD_LAT to 1..15.
    localparam int unsigned STALL_CNT_W = 4;

    // Largest supported load-use latency.
    localparam int unsigned LOAD_LAT_MAX = 15;

    // Architectural zero register; never a real producer.
    localparam int unsigned X0 = 0;

    // Hazard sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hdu_state_e;

    // Clamp a requested load latency into the supported 1..15 range.
    function automatic int unsigned clamp_lat(input int unsigned lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > LOAD_LAT_MAX) begin
            return LOAD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// ID/EX hazard interface: pipeline-side master drives decode/EX info, unit answers.
interface hazard_detect_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic              rs1_used_i;
    logic              rs2_used_i;
    logic              ex_memread_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              mem_stall_i;
    logic              flush_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              noop_o;
    logic              stall_active_o;
    logic [CNT_W-1:0]  stall_cycles_o;
    logic [CNT_W-1:0]  hazard_events_o;

    // Pipeline side.
    modport master (
        output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output ex_memread_i, ex_rd_i, mem_stall_i, flush_i,
        input  pc_write_o, ifid_write_o, noop_o, stall_active_o,
        input  stall_cycles_o, hazard_events_o
    );

    // Hazard unit side.
    modport slave (
        input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  ex_memread_i, ex_rd_i, mem_stall_i, flush_i,
        output pc_write_o, ifid_write_o, noop_o, stall_active_o,
        output stall_cycles_o, hazard_events_o
    );

endinterface

// File: rtl/hazard_detect_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);

    logic at_max_c;

    // Saturation point reached.
    assign at_max_c = (value == {W{1'b1}});

    // Counter register with synchronous clear taking priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && !at_max_c) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection between ID and EX with multi-cycle bubble sequencing,
// memory freeze, branch flush and saturating performance counters.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_detect_unit_if.slave hd
);

    // Effective latency and the counter value loaded on entry to STALL.
    // The detect cycle is bubble one and the cnt==0 STALL cycle is the last,
    // hence the load value of LAT-2.
    localparam int unsigned LAT_EFF = clamp_lat(LOAD_LAT);
    localparam logic [STALL_CNT_W-1:0] CNT_LOAD =
        (LAT_EFF > 1) ? STALL_CNT_W'(LAT_EFF - 2) : '0;
    localparam logic MULTI_CYCLE = (LAT_EFF > 1);

    hdu_state_e             state_q;
    hdu_state_e             state_d;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;

    logic rs1_match_c;
    logic rs2_match_c;
    logic hz_c;
    logic pc_write_c;
    logic ifid_write_c;
    logic noop_c;
    logic inc_stall_c;
    logic inc_event_c;

    // Load-use comparator; x0 and unused sources never match.
    assign rs1_match_c = hd.rs1_used_i && (hd.rs1_addr_i == hd.ex_rd_i);
    assign rs2_match_c = hd.rs2_used_i && (hd.rs2_addr_i == hd.ex_rd_i);
    assign hz_c        = hd.ex_memread_i
                      && (hd.ex_rd_i != REG_AW'(X0))
                      && (rs1_match_c || rs2_match_c);

    // Next-state and front-end control, priority: freeze, flush, stall, detect.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        noop_c       = 1'b0;
        inc_stall_c  = 1'b0;
        inc_event_c  = 1'b0;

        if (hd.mem_stall_i) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (hd.flush_i) begin
            noop_c  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_STALL) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            noop_c       = 1'b1;
            inc_stall_c  = 1'b1;
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - STALL_CNT_W'(1);
            end
        end else if (hz_c) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            noop_c       = 1'b1;
            inc_stall_c  = 1'b1;
            inc_event_c  = 1'b1;
            if (MULTI_CYCLE) begin
                state_d = ST_STALL;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    // Sequencer state and bubble counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Front-end control is combinational so the detect cycle bubbles immediately.
    assign hd.pc_write_o     = pc_write_c;
    assign hd.ifid_write_o   = ifid_write_c;
    assign hd.noop_o         = noop_c;
    assign hd.stall_active_o = (state_q == ST_STALL);

    // Bubble cycles issued.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cycles (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (inc_stall_c),
        .clear (1'b0),
        .value (hd.stall_cycles_o)
    );

    // Hazards detected.
    sat_counter #(
        .W (CNT_W)
    ) u_hazard_events (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (inc_event_c),
        .clear (1'b0),
        .value (hd.hazard_events_o)
    );

endmodule
